// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned NxN->2N shift-and-add multiplier built around a ripple-carry adder
module multi_bit_full_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] input_a,
  input  logic [N-1:0] input_b,
  input  logic         input_carry,
  output logic [N-1:0] output_sum,
  output logic         output_carry
);
  logic [N:0] c;
  assign c[0] = input_carry;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign output_sum[i] = input_a[i] ^ input_b[i] ^ c[i];
    assign c[i+1] = (input_a[i] & input_b[i]) | (c[i] & (input_a[i] ^ input_b[i]));
  end
  assign output_carry = c[N];
endmodule

module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           input_start,
  input  logic [N-1:0]   input_a,
  input  logic [N-1:0]   input_b,
  output logic [2*N-1:0] output_product,
  output logic           output_busy,
  output logic           output_valid
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] mcand_q, mcand_d;
  logic [2*N:0] acc_q, acc_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [N-1:0] add_sum;
  logic add_carry;
  logic unused_acc_msb;
  // The top accumulator bit is always shifted back to zero; it only exists to catch the adder carry.
  assign unused_acc_msb = acc_q[2*N];
  multi_bit_full_adder #(.N(N)) u_adder (
    .input_a      (acc_q[2*N-1:N]),
    .input_b      (acc_q[0] ? mcand_q : '0),
    .input_carry  (1'b0),
    .output_sum   (add_sum),
    .output_carry (add_carry)
  );
  // Next-state: accept in IDLE, one add-and-shift per CALC cycle, publish the product as DONE is entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    if (state_q == IDLE && input_start) begin
      state_d = CALC;
      cnt_d   = '0;
      mcand_d = input_a;
      acc_d   = {{(N+1){1'b0}}, input_b};
    end else if (state_q == CALC) begin
      acc_d = {1'b0, add_carry, add_sum, acc_q[N-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = DONE;
        prod_d  = acc_d[2*N-1:0];
      end
    end else begin
      state_d = IDLE;
    end
  end
  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end
  assign output_product = prod_q;
  assign output_busy    = state_q != IDLE;
  assign output_valid   = state_q == DONE;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: vector, random and corner-sequence checks of shift_add_multiplier at N=4, 8 and 16
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic st4, st8, st16;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic [15:0] a16, b16;
  logic [7:0] p4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic bz4, bz8, bz16, v4, v8, v16;
  int total = 0;
  int bad = 0;
  shift_add_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .input_start(st4), .input_a(a4), .input_b(b4),
    .output_product(p4), .output_busy(bz4), .output_valid(v4));
  shift_add_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .input_start(st8), .input_a(a8), .input_b(b8),
    .output_product(p8), .output_busy(bz8), .output_valid(v8));
  shift_add_multiplier #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .input_start(st16), .input_a(a16), .input_b(b16),
    .output_product(p16), .output_busy(bz16), .output_valid(v16));
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] p;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic drive(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
    if (w == 4) begin st4 = s; a4 = a[3:0]; b4 = b[3:0]; end
    else if (w == 8) begin st8 = s; a8 = a[7:0]; b8 = b[7:0]; end
    else begin st16 = s; a16 = a; b16 = b; end
  endtask
  function automatic logic busy_of(input int w);
    return w == 4 ? bz4 : w == 8 ? bz8 : bz16;
  endfunction
  function automatic logic valid_of(input int w);
    return w == 4 ? v4 : w == 8 ? v8 : v16;
  endfunction
  function automatic logic [31:0] prod_of(input int w);
    return w == 4 ? {24'd0, p4} : w == 8 ? {16'd0, p8} : p16;
  endfunction
  // One operation: start asserted in cycle 1, optional extra start pulse in cycle hit_at,
  // operands scrambled afterwards; valid must land in cycle w+2 with busy high w+1 cycles.
  task automatic op(input string nm, input int w, input logic [15:0] a, input logic [15:0] b,
                    input int hit_at, input logic [15:0] ha, input logic [15:0] hb,
                    input logic [31:0] exp);
    logic [31:0] pre, p;
    int vpos, vcnt, bcnt;
    bit stable;
    p = 'x; vpos = 0; vcnt = 0; bcnt = 0; stable = 1;
    @(negedge clk);
    pre = prod_of(w);
    drive(w, 1'b1, a, b);
    for (int c = 2; c <= w + 8; c++) begin
      @(negedge clk);
      drive(w, c == hit_at, c == hit_at ? ha : 16'($urandom), c == hit_at ? hb : 16'($urandom));
      if (busy_of(w)) bcnt++;
      if (valid_of(w)) begin
        vcnt++;
        if (vpos == 0) begin vpos = c; p = prod_of(w); end
      end else if (vpos == 0 && prod_of(w) !== pre) stable = 0;
      else if (vpos != 0 && prod_of(w) !== p) stable = 0;
    end
    drive(w, 1'b0, 16'd0, 16'd0);
    chk({nm, " product"}, p, exp);
    chk({nm, " latency"}, 32'(vpos), 32'(w + 2));
    chk({nm, " valid_pulses"}, 32'(vcnt), 32'd1);
    chk({nm, " busy_cycles"}, 32'(bcnt), 32'(w + 1));
    chk({nm, " product_hold"}, 32'(stable), 32'd1);
  endtask
  initial begin
    int v1, v2, vr;
    logic [31:0] q1, q2, ra, rb;
    drive(4, 1'b0, 16'd0, 16'd0);
    drive(8, 1'b0, 16'd0, 16'd0);
    drive(16, 1'b0, 16'd0, 16'd0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #11;
    chk("rst p8", {16'd0, p8}, 32'd0);
    chk("rst busy8", {31'd0, bz8}, 32'd0);
    chk("rst valid8", {31'd0, v8}, 32'd0);
    chk("rst p4", {24'd0, p4}, 32'd0);
    chk("rst p16", p16, 32'd0);
    chk("rst busy16", {31'd0, bz16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vecs[0] = '{8'd13, 8'd11, 32'd143};
    vecs[1] = '{8'd255, 8'd255, 32'd65025};
    vecs[2] = '{8'd0, 8'd200, 32'd0};
    vecs[3] = '{8'd200, 8'd0, 32'd0};
    vecs[4] = '{8'd1, 8'd1, 32'd1};
    vecs[5] = '{8'd255, 8'd1, 32'd255};
    vecs[6] = '{8'd128, 8'd2, 32'd256};
    foreach (vecs[i]) op($sformatf("vec%0d", i), 8, {8'd0, vecs[i].a}, {8'd0, vecs[i].b}, 0, 16'd0, 16'd0, vecs[i].p);
    op("busy_ignore", 8, 16'd6, 16'd7, 4, 16'd9, 16'd9, 32'd42);
    for (int i = 0; i < 20; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      op("rand8", 8, ra[15:0], rb[15:0], 0, 16'd0, 16'd0, ra * rb);
    end
    v1 = 0; v2 = 0; q1 = 'x; q2 = 'x;
    @(negedge clk);
    drive(8, 1'b1, 16'd3, 16'd5);
    for (int c = 2; c <= 40 && v2 == 0; c++) begin
      @(negedge clk);
      if (v8) begin
        if (v1 == 0) begin v1 = c; q1 = {16'd0, p8}; drive(8, 1'b1, 16'd100, 16'd2); end
        else begin v2 = c; q2 = {16'd0, p8}; drive(8, 1'b0, 16'd0, 16'd0); end
      end
    end
    drive(8, 1'b0, 16'd0, 16'd0);
    chk("b2b first product", q1, 32'd15);
    chk("b2b second product", q2, 32'd200);
    chk("b2b first latency", 32'(v1), 32'd10);
    chk("b2b spacing", 32'(v2 - v1), 32'd10);
    repeat (12) @(negedge clk);
    chk("b2b idle after", {31'd0, bz8}, 32'd0);
    @(negedge clk);
    drive(8, 1'b1, 16'd50, 16'd50);
    @(negedge clk);
    drive(8, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, bz8}, 32'd0);
    chk("midrst valid", {31'd0, v8}, 32'd0);
    chk("midrst product", {16'd0, p8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vr = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (v8 || bz8) vr++;
    end
    chk("midrst no activity", 32'(vr), 32'd0);
    op("after_rst", 8, 16'd2, 16'd3, 0, 16'd0, 16'd0, 32'd6);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op("n4", 4, 16'(a), 16'(b), 0, 16'd0, 16'd0, 32'(a * b));
    op("n16max", 16, 16'hFFFF, 16'hFFFF, 0, 16'd0, 16'd0, 32'hFFFE0001);
    op("n16ignore", 16, 16'd1000, 16'd3, 6, 16'd7, 16'd7, 32'd3000);
    for (int i = 0; i < 5; i++) begin
      ra = $urandom_range(0, 65535);
      rb = $urandom_range(0, 65535);
      op("rand16", 16, ra[15:0], rb[15:0], 0, 16'd0, 16'd0, ra * rb);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
